// File: rtl/bus_dma_pkg.sv
// Shared definitions for the word-copy DMA engine: FSM state encoding and the
// constant byte-enable pattern driven on every bus access.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } dma_state_e;

    localparam logic [3:0] BUS_BE_FULL = 4'hf;

endpackage

// File: rtl/bus_dma_copy.sv
// Word-copy DMA engine: moves len_bi 32-bit words from src to dst over a req/ack/resp bus.
// Optional BUS_DMA_COPY_FILL_EN adds a fill mode that writes a constant word instead of copying.
module bus_dma_copy
    import bus_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_bi,
    input  logic [31:0]      dst_addr_bi,
    input  logic [LEN_W-1:0] len_bi,
`ifdef BUS_DMA_COPY_FILL_EN
    input  logic             fill_i,
    input  logic [31:0]      fill_data_bi,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [31:0]      bus_addr_bo,
    output logic [3:0]       bus_be_bo,
    output logic [31:0]      bus_wdata_bo,
    input  logic             bus_ack_i,
    input  logic             bus_resp_i,
    input  logic [31:0]      bus_rdata_bi
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;
`ifdef BUS_DMA_COPY_FILL_EN
    logic             fill_q, fill_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
`ifdef BUS_DMA_COPY_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
`ifdef BUS_DMA_COPY_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first, so no path through the case infers a latch.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
`ifdef BUS_DMA_COPY_FILL_EN
        fill_d  = fill_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d = src_addr_bi & 32'hffff_fffc;
                    dst_d = dst_addr_bi & 32'hffff_fffc;
                    rem_d = len_bi;
`ifdef BUS_DMA_COPY_FILL_EN
                    fill_d = fill_i;
                    if (fill_i) data_d = fill_data_bi;
                    if (len_bi == '0)  state_d = ST_DONE;
                    else if (fill_i)   state_d = ST_WR_REQ;
                    else               state_d = ST_RD_REQ;
`else
                    state_d = (len_bi == '0) ? ST_DONE : ST_RD_REQ;
`endif
                end
            end
            ST_RD_REQ: begin
                if (bus_ack_i) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus_resp_i) begin
                    data_d  = bus_rdata_bi;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (bus_ack_i) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
`ifdef BUS_DMA_COPY_FILL_EN
                    else if (fill_q)        state_d = ST_WR_REQ;
`endif
                    else                    state_d = ST_RD_REQ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs derive only from state and registers, so they stay frozen while waiting for ack.
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign bus_req_o    = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign bus_we_o     = (state_q == ST_WR_REQ);
    assign bus_addr_bo  = (state_q == ST_WR_REQ) ? dst_q : src_q;
    assign bus_wdata_bo = data_q;
    assign bus_be_bo    = BUS_BE_FULL;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Self-checking bench for bus_dma_copy: a memory responder with programmable ack/resp
// delays, and a sequential word-by-word reference model of the copy/fill transfer.
module tb_bus_dma_copy;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [31:0]      src_addr_bi = '0;
    logic [31:0]      dst_addr_bi = '0;
    logic [LEN_W-1:0] len_bi = '0;
`ifdef BUS_DMA_COPY_FILL_EN
    logic             fill_i = 1'b0;
    logic [31:0]      fill_data_bi = '0;
`endif
    logic             busy_o, done_o;
    logic             bus_req_o, bus_we_o;
    logic [31:0]      bus_addr_bo, bus_wdata_bo;
    logic [3:0]       bus_be_bo;
    logic             bus_ack_i = 1'b0;
    logic             bus_resp_i = 1'b0;
    logic [31:0]      bus_rdata_bi = '0;

    bus_dma_copy #(.LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .src_addr_bi  (src_addr_bi),
        .dst_addr_bi  (dst_addr_bi),
        .len_bi       (len_bi),
`ifdef BUS_DMA_COPY_FILL_EN
        .fill_i       (fill_i),
        .fill_data_bi (fill_data_bi),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_bo  (bus_addr_bo),
        .bus_be_bo    (bus_be_bo),
        .bus_wdata_bo (bus_wdata_bo),
        .bus_ack_i    (bus_ack_i),
        .bus_resp_i   (bus_resp_i),
        .bus_rdata_bi (bus_rdata_bi)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: everything happens on the falling edge, half a cycle from the DUT's edge.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mem_seed = 32'h1234_5678;
    txn_t        log_q[$];
    txn_t        cur_txn;
    int          ack_wait = 0, resp_extra = 0;
    int          wait_cnt = 0, resp_cnt = 0;
    bit          resp_pend = 0, holding = 0;
    logic [31:0] resp_data, hold_addr, hold_wdata;
    logic        hold_we;
    int          stable_err = 0, be_err = 0, req_cycles = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ mem_seed;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            bus_ack_i  = 1'b0;
            bus_resp_i = 1'b0;
            resp_pend  = 0;
            holding    = 0;
            wait_cnt   = 0;
        end else begin
            bus_resp_i   = 1'b0;
            bus_rdata_bi = $urandom;
            if (bus_ack_i) begin
                bus_ack_i = 1'b0;
                log_q.push_back(cur_txn);
                if (cur_txn.we) mem[cur_txn.addr] = cur_txn.data;
                else begin
                    resp_pend = 1;
                    resp_cnt  = resp_extra;
                    resp_data = mem_read(cur_txn.addr);
                end
            end
            if (resp_pend) begin
                if (resp_cnt == 0) begin
                    bus_resp_i   = 1'b1;
                    bus_rdata_bi = resp_data;
                    resp_pend    = 0;
                end else resp_cnt--;
            end
            if (bus_be_bo !== 4'hf) be_err++;
            if (bus_req_o) begin
                req_cycles++;
                if (!holding) begin
                    holding    = 1;
                    hold_we    = bus_we_o;
                    hold_addr  = bus_addr_bo;
                    hold_wdata = bus_wdata_bo;
                end else if (bus_we_o !== hold_we || bus_addr_bo !== hold_addr ||
                             bus_wdata_bo !== hold_wdata) begin
                    stable_err++;
                end
                if (wait_cnt >= ack_wait) begin
                    bus_ack_i = 1'b1;
                    cur_txn   = '{we: bus_we_o, addr: bus_addr_bo, data: bus_wdata_bo};
                    wait_cnt  = 0;
                    holding   = 0;
                end else wait_cnt++;
            end
        end
    end

    // One transfer: start, watch for done within a cycle budget, then compare the bus
    // traffic and memory against a word-by-word reference of the copy/fill rules.
    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input bit fill, input logic [31:0] fdata,
                            input int aw, input int re, input bit stray);
        logic [31:0] ref_mem [logic [31:0]];
        txn_t        exp_q[$];
        logic [31:0] a, d, w;
        int          lat, done_cnt, exp_lat, exp_req, extra;

        ack_wait   = aw;
        resp_extra = re;
        log_q.delete();
        stable_err = 0;
        req_cycles = 0;
        ref_mem    = mem;

        @(negedge clk_i);
        #1;
        src_addr_bi = src;
        dst_addr_bi = dst;
        len_bi      = LEN_W'(n);
`ifdef BUS_DMA_COPY_FILL_EN
        fill_i       = fill;
        fill_data_bi = fdata;
`endif
        start_i = 1'b1;
        lat = -1;
        done_cnt = 0;
        extra = 0;
        for (int k = 1; k <= 3000 && extra < 3; k++) begin
            @(negedge clk_i);
            #1;
            if (done_o) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0) extra++;
            if (stray && lat < 0 && !done_o) begin
                start_i     = 1'($urandom_range(0, 1));
                src_addr_bi = $urandom;
                dst_addr_bi = $urandom;
                len_bi      = LEN_W'($urandom);
`ifdef BUS_DMA_COPY_FILL_EN
                fill_i       = 1'($urandom_range(0, 1));
                fill_data_bi = $urandom;
`endif
            end else start_i = 1'b0;
        end
        start_i = 1'b0;

        a = src & 32'hffff_fffc;
        d = dst & 32'hffff_fffc;
        for (int i = 0; i < n; i++) begin
            if (fill) w = fdata;
            else begin
                w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
            end
            ref_mem[d] = w;
            exp_q.push_back('{we: 1'b1, addr: d, data: w});
            a += 32'd4;
            d += 32'd4;
        end
        exp_lat = fill ? n * (aw + 1) + 1 : n * (2 * aw + re + 3) + 1;
        exp_req = fill ? n * (aw + 1) : 2 * n * (aw + 1);

        check({tag, "_done_lat"}, lat, exp_lat);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_idle_after"}, {31'b0, busy_o}, 0);
        check({tag, "_req_cycles"}, req_cycles, exp_req);
        check({tag, "_stable"}, stable_err, 0);
        check({tag, "_ntxn"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_we%0d", tag, i), {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
            check($sformatf("%s_addr%0d", tag, i), log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) begin
                check($sformatf("%s_wdata%0d", tag, i), log_q[i].data, exp_q[i].data);
                check($sformatf("%s_mem%0d", tag, i), mem_read(exp_q[i].addr), ref_mem[exp_q[i].addr]);
            end
        end
    endtask

    initial begin
        int found;
        mem_seed = $urandom;

        // Reset state, sampled while rst_i is still high.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_busy", {31'b0, busy_o}, 0);
        check("rst_done", {31'b0, done_o}, 0);
        check("rst_req", {31'b0, bus_req_o}, 0);
        check("rst_we", {31'b0, bus_we_o}, 0);
        check("rst_be", {28'b0, bus_be_bo}, 32'hf);
        rst_i = 1'b0;

        run_xfer("copy4", 32'h100, 32'h200, 4, 1'b0, 32'h0, 0, 0, 1'b0);
        run_xfer("len0", 32'h100, 32'h200, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        run_xfer("slow", 32'h0000_1003, 32'h0000_2002, 3, 1'b0, 32'h0, 3, 2, 1'b0);
        run_xfer("wrap", 32'hffff_fffc, 32'h0000_3000, 2, 1'b0, 32'h0, 0, 0, 1'b0);
        check("wrap_rd2_addr", log_q.size() > 2 ? log_q[2].addr : 32'hffff_ffff, 32'h0);

        // Reset while a write is waiting for its ack.
        ack_wait = 3;
        resp_extra = 0;
        @(negedge clk_i);
        #1;
        src_addr_bi = 32'h300;
        dst_addr_bi = 32'h400;
        len_bi      = LEN_W'(3);
`ifdef BUS_DMA_COPY_FILL_EN
        fill_i = 1'b0;
`endif
        start_i = 1'b1;
        @(negedge clk_i);
        #1;
        start_i = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (bus_req_o && bus_we_o) found = 1;
            else begin
                @(negedge clk_i);
                #1;
            end
        end
        check("rstmid_saw_wr", found, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rstmid_req", {31'b0, bus_req_o}, 0);
        check("rstmid_we", {31'b0, bus_we_o}, 0);
        check("rstmid_busy", {31'b0, busy_o}, 0);
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b0;
        found = 0;
        repeat (10) begin
            @(negedge clk_i);
            #1;
            if (done_o) found++;
        end
        check("rstmid_no_done", found, 0);
        run_xfer("after_rst", 32'h500, 32'h600, 2, 1'b0, 32'h0, 0, 0, 1'b0);

`ifdef BUS_DMA_COPY_FILL_EN
        run_xfer("fill3", 32'h700, 32'h800, 3, 1'b1, 32'hdead_beef, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            bit fill_r;
            fill_r = 1'b0;
`ifdef BUS_DMA_COPY_FILL_EN
            fill_r = 1'($urandom_range(0, 1));
`endif
            run_xfer($sformatf("rnd%0d", i), $urandom, $urandom, $urandom_range(0, 6), fill_r,
                     $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        end

        check("be_always_full", be_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
